// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two requesters share one WIDTH-bit equality comparator.
// A round-robin arbiter picks one request at a time. The pair is latched and
// compared in BUSY, and the result is held in RESP until the owner takes it.
// Optional feature macro: CMP_ARBITER_STAT_EN adds two 16-bit saturating
// per-requester grant counters (grant0_cnt, grant1_cnt).
//
// Handshake semantics, for both request and response channels: a transfer
// happens on a rising clk edge where valid and ready are both 1. A requester
// may drop valid before ready and is then not captured. A response stays
// valid, with resp_eq unchanged, until its owner's ready is seen; there is
// no timeout.
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    // requester 0 (branch unit)
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    // requester 1 (trap unit)
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    // shared response channel, qualified per owner
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic             resp_eq,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
`ifdef CMP_ARBITER_STAT_EN
    output logic [15:0]      grant0_cnt,
    output logic [15:0]      grant1_cnt,
`endif
    // FSM state for observation: 0 = IDLE, 1 = BUSY, 2 = RESP
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             owner_q;   // requester that owns the current operation
    logic             rr_last;   // requester granted most recently
    logic             any_valid;
    logic             sel_owner; // requester that would win a grant this cycle
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             hs;        // a request handshake happens this cycle
    logic             owner_ack; // the owner consumes its response this cycle
    logic             cmp_eq;

    assign dbg_state = state;

    // Pick a requester: a lone requester wins; on contention the one not
    // granted most recently wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        sel_owner = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_owner = ~rr_last;
        end else if (req1_valid) begin
            sel_owner = 1'b1;
        end
        sel_a = sel_owner ? req1_a : req0_a;
        sel_b = sel_owner ? req1_b : req0_b;
    end

    // The single shared comparator, fed only by the latched operands so that
    // operand changes after the handshake cannot reach the result.
    assign cmp_eq = (a_q == b_q);

    // Next-state and handshake outputs; readies are held low during reset.
    always_comb begin
        state_nxt   = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        hs          = 1'b0;
        owner_ack   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reset && any_valid) begin
                    req0_ready = ~sel_owner;
                    req1_ready = sel_owner;
                    hs         = 1'b1;
                    state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp0_valid = ~owner_q;
                resp1_valid = owner_q;
                owner_ack   = owner_q ? resp1_ready : resp0_ready;
                if (owner_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, operand latch, owner, round-robin pointer and registered result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            owner_q <= 1'b0;
            rr_last <= 1'b1;   // requester 0 wins the first contention
            resp_eq <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                a_q     <= sel_a;
                b_q     <= sel_b;
                owner_q <= sel_owner;
                rr_last <= sel_owner;
            end
            if (state == ST_BUSY) begin
                resp_eq <= cmp_eq;
            end
        end
    end

`ifdef CMP_ARBITER_STAT_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (req0_valid && req0_ready && grant0_cnt != CNT_MAX) begin
                grant0_cnt <= grant0_cnt + 16'd1;
            end
            if (req1_valid && req1_ready && grant1_cnt != CNT_MAX) begin
                grant1_cnt <= grant1_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: randomized and directed checks of cmp_arbiter against a
// transaction-level reference model. The model tracks who was granted last,
// and an expected-result queue holds the a==b value for each accepted pair.
module tb_cmp_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp1_valid, resp_eq;
    logic         resp0_ready, resp1_ready;
    logic [1:0]   dbg_state;
`ifdef CMP_ARBITER_STAT_EN
    logic [15:0]  grant0_cnt, grant1_cnt;
`endif

    int           vectors;
    int           miscompares;
    logic         model_last;   // requester granted most recently
    logic         exp_q[$];     // expected resp_eq per accepted pair
    int           exp_g0, exp_g1;

    cmp_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_eq(resp_eq),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
`ifdef CMP_ARBITER_STAT_EN
        .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input logic v0, input logic v1);
        // Lone requester wins; on contention, whoever was not granted last.
        if (v0 && v1) return (model_last == 1'b1) ? 1'b0 : 1'b1;
        return v1 ? 1'b1 : 1'b0;
    endfunction

    // One full transaction: offer, handshake, BUSY, RESP held 'hold' cycles.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input int hold, input logic poke_other);
        logic own;
        logic want;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(negedge clk);
        if (!v0 && !v1) begin
            vectors++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                miscompares++;
                $display("FAIL idle_ready: got %b want 00", {req0_ready, req1_ready});
            end
            step();
            return;
        end
        own = pick(v0, v1);
        exp_q.push_back(own ? (a1 == b1) : (a0 == b0));
        vectors++;
        if ({req0_ready, req1_ready} !== {~own, own}) begin
            miscompares++;
            $display("FAIL grant: got ready=%b want %b", {req0_ready, req1_ready}, {~own, own});
        end
        step();
        model_last = own;
        if (own) exp_g1++; else exp_g0++;
        // Scramble operands and valids; neither may influence this result.
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        vectors++;
        if ({resp0_valid, resp1_valid, req0_ready, req1_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL busy: got rv=%b rr=%b want 00 00", {resp0_valid, resp1_valid},
                     {req0_ready, req1_ready});
        end
        step();
        want = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            if (own) begin resp1_ready = (h == hold); resp0_ready = poke_other; end
            else     begin resp0_ready = (h == hold); resp1_ready = poke_other; end
            req1_a = $urandom;
            @(negedge clk);
            vectors++;
            if ({resp0_valid, resp1_valid, resp_eq, req0_ready, req1_ready} !==
                {~own, own, want, 2'b00}) begin
                miscompares++;
                $display("FAIL resp[%0d]: got rv=%b eq=%b rr=%b want rv=%b eq=%b rr=00", h,
                         {resp0_valid, resp1_valid}, resp_eq, {req0_ready, req1_ready},
                         {~own, own}, want);
            end
            step();
        end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        model_last = 1'b1;
        exp_q.delete();
        exp_g0 = 0; exp_g1 = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_eq, dbg_state} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_state: got rr=%b rv=%b eq=%b st=%0d want all 0",
                     {req0_ready, req1_ready}, {resp0_valid, resp1_valid}, resp_eq, dbg_state);
        end
        step();
        reset = 1'b1;
        model_last = 1'b1;
        exp_g0 = 0; exp_g1 = 0;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_contention();
        for (int i = 0; i < 3; i++)
            run_txn(1'b1, 1'b1, 32'd5, 32'd5, 32'd5, 32'd6, 0, 1'b0);
    endtask

    task automatic test_single();
        run_txn(1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 1'b1, 32'h0, 32'h0, 32'hCAFE_0001, 32'hCAFE_0001, 4, 1'b1);
        run_txn(1'b0, 1'b1, 32'h0, 32'h0, 32'hCAFE_0001, 32'hCAFE_0002, 4, 1'b1);
    endtask

    task automatic test_width_edge();
        run_txn(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h1, 32'h1, 32'h0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        // Leave resp_eq=1 registered, then abort the next operation in BUSY.
        run_txn(1'b0, 1'b1, 32'h0, 32'h0, 32'h77, 32'h77, 0, 1'b0);
        req0_valid = 1'b1; req0_a = 32'h9; req0_b = 32'h9; req1_valid = 1'b0;
        step();                       // handshake; now in BUSY
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        step();
        @(negedge clk);
        vectors++;
        if ({dbg_state, resp0_valid, resp1_valid, resp_eq} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_abort: got st=%0d rv=%b eq=%b want 0 00 0", dbg_state,
                     {resp0_valid, resp1_valid}, resp_eq);
        end
        step();
        reset = 1'b1;
        model_last = 1'b1;
        exp_g0 = 0; exp_g1 = 0;
        run_txn(1'b1, 1'b1, 32'h3, 32'h4, 32'h8, 32'h8, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Both requesters always valid and responses always consumed: one
        // grant every 3 cycles, result visible 2 cycles after each grant.
        logic own;
        logic want;
        own = 1'b0;
        want = 1'b0;
        req0_valid = 1'b1; req0_a = 32'hA5A5_0000; req0_b = 32'hA5A5_0000;
        req1_valid = 1'b1; req1_a = 32'h1;         req1_b = 32'h2;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                own = pick(1'b1, 1'b1);
                want = own ? 1'b0 : 1'b1;
            end
            vectors++;
            if ({req0_ready, req1_ready} !== ((k % 3 == 0) ? {~own, own} : 2'b00)) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: got %b", k, {req0_ready, req1_ready});
            end
            if (k % 3 == 2) begin
                vectors++;
                if ({resp0_valid, resp1_valid, resp_eq} !== {~own, own, want}) begin
                    miscompares++;
                    $display("FAIL b2b_resp[%0d]: got rv=%b eq=%b want rv=%b eq=%b", k,
                             {resp0_valid, resp1_valid}, resp_eq, {~own, own}, want);
                end
            end
            step();
            if (k % 3 == 0) begin
                model_last = own;
                if (own) exp_g1++; else exp_g0++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] a0, b0, a1, b1;
        for (int i = 0; i < 40; i++) begin
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 1) == 1) ? a0 : W'($urandom);
            b1 = ($urandom_range(0, 1) == 1) ? a1 : (a1 ^ (W'(1) << $urandom_range(0, W - 1)));
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0, b0, a1, b1,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef CMP_ARBITER_STAT_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) run_txn(1'b1, 1'b0, 32'h1, 32'h1, 32'h0, 32'h0, 0, 1'b0);
        for (int i = 0; i < 2; i++) run_txn(1'b0, 1'b1, 32'h0, 32'h0, 32'h2, 32'h3, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if (grant0_cnt !== 16'(exp_g0) || grant1_cnt !== 16'(exp_g1)) begin
            miscompares++;
            $display("FAIL stat_cnt: got %0d/%0d want %0d/%0d", grant0_cnt, grant1_cnt,
                     exp_g0, exp_g1);
        end
        force dut.grant0_cnt = 16'hFFFF;
        step();
        release dut.grant0_cnt;
        run_txn(1'b1, 1'b0, 32'h1, 32'h1, 32'h0, 32'h0, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if (grant0_cnt !== 16'hFFFF || grant1_cnt !== 16'(exp_g1)) begin
            miscompares++;
            $display("FAIL stat_sat: got %h/%0d want ffff/%0d", grant0_cnt, grant1_cnt, exp_g1);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        model_last = 1'b1;
        exp_g0 = 0;
        exp_g1 = 0;
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_width_edge();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef CMP_ARBITER_STAT_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
